// File: rtl/mux4_way_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_way_arbiter_pkg
// Shared constants for the 4-way round-robin arbiter/mux and its picker.
//   NUM_CH    : number of input channels (4)
//   SEL_W     : width of a channel index / select (2)
//   ST_EMPTY  : output register holds no word
//   ST_FULL   : output register holds a word waiting for downstream
//   nextCh()  : channel index + 1, wrapping 3 -> 0
// ---------------------------------------------------------------------------
package mux4_way_arbiter_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // The select is exactly as wide as the channel count needs, so the
    // natural 2-bit overflow gives the round-robin wrap for free.
    function automatic logic [SEL_W-1:0] nextCh(input logic [SEL_W-1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/mux4_way_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational 4-request round-robin priority picker.
//   request    (in)  : one bit per channel asking for service
//   last_grant (in)  : index of the most recently served channel
//   grant      (out) : one-hot winner, zero when nothing is requested
//   index      (out) : binary index of the winner (0 when nothing requested)
//   any        (out) : at least one request present
// The search begins just after last_grant and walks upward with wrap, so
// the channel that was just served has the lowest priority next time.
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_way_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] request,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  index,
    output logic              any
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = nextCh(last_grant);
        for (int k = 0; k < NUM_CH; k++) begin
            // Only the first requesting candidate in rotation order wins.
            if (!any && request[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                any         = 1'b1;
            end
            cand = nextCh(cand);
        end
    end

endmodule

// File: rtl/mux4_way_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_way_arbiter
// Four valid/ready input channels merged round-robin into one registered
// valid/ready output.
//   clk       (in)  : clock, all state updates on the rising edge
//   reset_n   (in)  : asynchronous active-low reset
//   in_valid  (in)  : per-channel request, bit i = channel i
//   in_data   (in)  : channel i data in bits [i*WIDTH +: WIDTH]
//   in_ready  (out) : one-hot (or zero) accept strobe, combinational
//   out_valid (out) : output register holds a word
//   out_data  (out) : registered data of the granted word
//   out_sel   (out) : index of the channel out_data came from
//   out_ready (in)  : downstream accepts out_data when high with out_valid
// ---------------------------------------------------------------------------
module mux4_way_arbiter
    import mux4_way_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*WIDTH-1:0]  in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [0:0]        state_q, state_d;
    logic [SEL_W-1:0]  lastGrant_q, lastGrant_d;
    logic [WIDTH-1:0]  outData_q, outData_d;
    logic [SEL_W-1:0]  outSel_q, outSel_d;

    logic [NUM_CH-1:0] pickGrant;
    logic [SEL_W-1:0]  pickIndex;
    logic              pickAny;
    logic [WIDTH-1:0]  pickData;
    logic              slotFree;
    logic              load;

    rr_pick4 u_pick (
        .request    (in_valid),
        .last_grant (lastGrant_q),
        .grant      (pickGrant),
        .index      (pickIndex),
        .any        (pickAny)
    );

    // The register can take a new word when it is empty or when its current
    // word leaves this same cycle; that keeps one word per cycle flowing.
    // in_ready is also gated by reset_n so nothing is accepted while the
    // register is being held in reset.
    assign slotFree = (state_q == ST_EMPTY) || out_ready;
    assign load     = reset_n && slotFree && pickAny;
    assign in_ready = load ? pickGrant : '0;

    // 4:1 data select driven by the winner's index.
    always_comb begin
        pickData = in_data[int'(pickIndex)*WIDTH +: WIDTH];
    end

    // Next-state for the single output register: load wins over drain, so a
    // pop and a push in the same cycle leave the register FULL with new data.
    // Data and select only change on a load; when the register drains they
    // keep the last word.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        outData_d   = outData_q;
        outSel_d    = outSel_q;
        if (load) begin
            state_d     = ST_FULL;
            lastGrant_d = pickIndex;
            outData_d   = pickData;
            outSel_d    = pickIndex;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Reset leaves last grant at the top channel so channel 0 is searched
    // first; any word held at reset is simply dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            lastGrant_q <= SEL_W'(NUM_CH - 1);
            outData_q   <= '0;
            outSel_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            outData_q   <= outData_d;
            outSel_q    <= outSel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = outData_q;
    assign out_sel   = outSel_q;

endmodule

// File: tb/tb_mux4_way_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_way_arbiter
// Self-checking bench for mux4_way_arbiter: directed scenarios plus a long
// randomized run against a behavioural model and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_mux4_way_arbiter;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [3:0]       in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit               mFull;
    logic [WIDTH-1:0] mData;
    int               mSel;
    int               mLast;

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] data;
    } word_t;
    word_t sbq[$];
    int    waitCnt[4];

    mux4_way_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // 10 ns clock: rising edges at 5, 15, ...; inputs change at falling edges
    always #5 clk = ~clk;

    // Hard time limit so the bench always ends on its own
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Round-robin rule: first valid channel starting after the last winner
    function automatic int rrWinner(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] expReady();
        int w;
        if (reset_n !== 1'b1) return 4'b0000;
        if (mFull && !out_ready) return 4'b0000;
        w = rrWinner(in_valid, mLast);
        if (w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    task automatic modelReset();
        mFull = 1'b0;
        mData = '0;
        mSel  = 0;
        mLast = 3;
        sbq.delete();
        for (int i = 0; i < 4; i++) waitCnt[i] = 0;
    endtask

    // Step the model across one rising edge using the inputs currently driven
    task automatic advance();
        logic [3:0]       er;
        int               w;
        logic [WIDTH-1:0] d;
        word_t            wd;
        er = expReady();
        w  = rrWinner(in_valid, mLast);
        d  = (w >= 0) ? in_data[w*WIDTH +: WIDTH] : '0;
        @(posedge clk);
        if (er != 4'b0000) begin
            wd.ch   = w;
            wd.data = d;
            sbq.push_back(wd);
            mFull = 1'b1;
            mData = d;
            mSel  = w;
            mLast = w;
        end else if (mFull && out_ready) begin
            mFull = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic setChData(input logic [WIDTH-1:0] base);
        for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
    endtask

    task automatic test_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = '0;
        reset_n   = 1'b0;
        modelReset();
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_sel: got %0d expected 0", out_sel); end
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 4'b0000;
    endtask

    task automatic test_single();
        in_valid = 4'b0001;
        in_data  = '0;
        in_data[15:0] = 16'h1234;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_in_ready: got %b expected 0001", in_ready); end
        advance();
        in_valid = 4'b0000;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("[TB] FAIL single_out_data: got %h expected 1234", out_data); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("[TB] FAIL single_out_sel: got %0d expected 0", out_sel); end
        advance();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'h1234) begin errors++; $display("[TB] FAIL idle_hold_data: got %h expected 1234", out_data); end
        advance();
    endtask

    task automatic test_back_to_back();
        int expSeq[6] = '{0, 1, 2, 3, 0, 1};
        doReset();
        in_valid  = 4'b1111;
        setChData(16'hA000);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << expSeq[c])) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected %b", c, in_ready, 4'b0001 << expSeq[c]); end
            advance();
            #1;
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'(expSeq[c]) || out_data !== 16'hA000 + 16'(expSeq[c]))
                begin errors++; $display("[TB] FAIL b2b_out[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", c, out_valid, out_sel, out_data, expSeq[c], 16'hA000 + 16'(expSeq[c])); end
        end
    endtask

    task automatic test_backpressure();
        doReset();
        in_valid  = 4'b1111;
        setChData(16'hA000);
        out_ready = 1'b1;
        repeat (3) advance();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0000", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 16'hA002)
                begin errors++; $display("[TB] FAIL stall_hold[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a002", c, out_valid, out_sel, out_data); end
            advance();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("[TB] FAIL stall_release_grant: got %b expected 1000", in_ready); end
        advance();
        #1;
        checks++; if (out_sel !== 2'd3 || out_data !== 16'hA003) begin errors++; $display("[TB] FAIL stall_release_out: got sel=%0d data=%h expected sel=3 data=a003", out_sel, out_data); end
    endtask

    task automatic test_alternate();
        int expSeq[6] = '{1, 3, 1, 3, 1, 3};
        doReset();
        in_valid  = 4'b1010;
        setChData(16'hC000);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << expSeq[c])) begin errors++; $display("[TB] FAIL alt_in_ready[%0d]: got %b expected %b", c, in_ready, 4'b0001 << expSeq[c]); end
            advance();
        end
    endtask

    task automatic test_reset_full();
        doReset();
        in_valid = 4'b0001;
        in_data  = '0;
        in_data[15:0] = 16'hBEEF;
        out_ready = 1'b1;
        advance();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL full_before_reset: got v=%b data=%h expected v=1 data=beef", out_valid, out_data); end
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sel !== 2'd0)
            begin errors++; $display("[TB] FAIL async_reset: got v=%b data=%h sel=%0d expected v=0 data=0000 sel=0", out_valid, out_data, out_sel); end
        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = 4'b1111;
        setChData(16'hD000);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL first_grant_after_reset: got %b expected 0001", in_ready); end
        advance();
    endtask

    task automatic test_random();
        logic [3:0] er;
        int         w;
        word_t      wd;
        doReset();
        for (int n = 0; n < 10000; n++) begin
            in_valid  = 4'($urandom);
            for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = 16'($urandom);
            out_ready = ($urandom % 4) != 0;
            #1;
            er = expReady();
            checks++; if (in_ready !== er) begin errors++; $display("[TB] FAIL rnd_in_ready[%0d]: got %b expected %b", n, in_ready, er); end
            if (mFull && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL rnd_scoreboard_empty[%0d]: got pop expected none", n);
                end else begin
                    wd = sbq.pop_front();
                    checks++; if (out_valid !== 1'b1 || out_sel !== 2'(wd.ch) || out_data !== wd.data)
                        begin errors++; $display("[TB] FAIL rnd_out[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", n, out_valid, out_sel, out_data, wd.ch, wd.data); end
                end
            end else begin
                checks++; if (out_valid !== mFull) begin errors++; $display("[TB] FAIL rnd_out_valid[%0d]: got %b expected %b", n, out_valid, mFull); end
            end
            // Starvation: a continuously waiting channel sees at most 3 other grants
            w = (er != 4'b0000) ? rrWinner(in_valid, mLast) : -1;
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i]) waitCnt[i] = 0;
                else if (w == i) waitCnt[i] = 0;
                else if (w >= 0) begin
                    waitCnt[i]++;
                    checks++; if (waitCnt[i] > 3) begin errors++; $display("[TB] FAIL rnd_starve_ch%0d[%0d]: got %0d other grants expected at most 3", i, n, waitCnt[i]); end
                end
            end
            advance();
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 4'b0000;
        in_data   = '0;
        out_ready = 1'b0;
        modelReset();
        $display("[TB] starting mux4_way_arbiter bench");
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_alternate();
        test_reset_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
